// File: rtl/fetch1.sv
// fetch1: second fetch stage. Issues in-order imem requests, pairs responses with their PCs
// and queues them for decode. Define FETCH1_ERR_EN to carry a per-entry fetch error bit.
module fetch1 #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f0_valid_i,
    input  logic [63:0] f0_pc_i,
    input  logic        redir_i,
    output logic        stall_f0_o,
    output logic        imem_req_valid_o,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
`ifdef FETCH1_ERR_EN
    input  logic        imem_resp_err_i,
    output logic        f1_err_o,
`endif
    output logic        f1_valid_o,
    output logic [63:0] f1_pc_o,
    output logic [31:0] f1_inst_o,
    input  logic        dec_ready_i
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [63:0]      pc_r   [DEPTH];
    logic [31:0]      inst_r [DEPTH];
    logic [DEPTH-1:0] done_r;
`ifdef FETCH1_ERR_EN
    logic [DEPTH-1:0] err_r;
`endif

    logic [AW-1:0] head_r, tail_r, fill_ptr_r;
    logic [AW-1:0] head_s, tail_s, fill_ptr_s;
    logic [CW-1:0] occ_r, pend_r, drop_r;
    logic [CW-1:0] occ_s, pend_s, drop_s;
    logic          credit_full_s, accept_s, drop_hit_s, fill_s, pop_s;

    // Credit covers live entries plus responses still owed for flushed requests.
    assign credit_full_s    = ({1'b0, occ_r} + {1'b0, drop_r}) == (CW+1)'(DEPTH);
    assign imem_req_valid_o = rst_n & f0_valid_i & ~credit_full_s;
    assign stall_f0_o       = rst_n & (credit_full_s | ~imem_req_ready_i);
    assign imem_req_addr_o  = f0_pc_i;
    assign accept_s         = imem_req_valid_o & imem_req_ready_i;

    assign drop_hit_s = imem_resp_valid_i & (drop_r != {CW{1'b0}});
    assign fill_s     = imem_resp_valid_i & (drop_r == {CW{1'b0}});

    // Head slot can hold a stale done bit once it is empty, so gate on occupancy.
    assign f1_valid_o = rst_n & (occ_r != {CW{1'b0}}) & done_r[head_r] & ~redir_i;
    assign f1_pc_o    = pc_r[head_r];
    assign f1_inst_o  = inst_r[head_r];
`ifdef FETCH1_ERR_EN
    assign f1_err_o   = err_r[head_r];
`endif
    assign pop_s      = f1_valid_o & dec_ready_i;

    // Next pointers and counters; redirect restarts the queue at the current tail.
    always_comb begin
        head_s     = head_r;
        tail_s     = tail_r;
        fill_ptr_s = fill_ptr_r;
        occ_s      = occ_r;
        pend_s     = pend_r;
        drop_s     = drop_r;
        tail_s     = tail_r + AW'(accept_s);
        if (redir_i) begin
            head_s     = tail_r;
            fill_ptr_s = tail_r;
            occ_s      = CW'(accept_s);
            pend_s     = CW'(accept_s);
            drop_s     = drop_r + pend_r - CW'(imem_resp_valid_i);
        end else begin
            head_s     = head_r + AW'(pop_s);
            fill_ptr_s = fill_ptr_r + AW'(fill_s);
            occ_s      = occ_r + CW'(accept_s) - CW'(pop_s);
            pend_s     = pend_r + CW'(accept_s) - CW'(fill_s);
            drop_s     = drop_r - CW'(drop_hit_s);
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
            fill_ptr_r <= {AW{1'b0}};
            occ_r      <= {CW{1'b0}};
            pend_r     <= {CW{1'b0}};
            drop_r     <= {CW{1'b0}};
        end else begin
            head_r     <= head_s;
            tail_r     <= tail_s;
            fill_ptr_r <= fill_ptr_s;
            occ_r      <= occ_s;
            pend_r     <= pend_s;
            drop_r     <= drop_s;
        end
    end

    // Entry storage: pop clears done, responses fill the oldest pending slot, pushes open a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]   <= 64'h0;
                inst_r[i] <= 32'h0;
            end
            done_r <= {DEPTH{1'b0}};
`ifdef FETCH1_ERR_EN
            err_r  <= {DEPTH{1'b0}};
`endif
        end else begin
            if (pop_s) begin
                done_r[head_r] <= 1'b0;
            end
            if (fill_s && !redir_i) begin
                inst_r[fill_ptr_r] <= imem_resp_data_i;
                done_r[fill_ptr_r] <= 1'b1;
`ifdef FETCH1_ERR_EN
                err_r[fill_ptr_r]  <= imem_resp_err_i;
`endif
            end
            if (accept_s) begin
                pc_r[tail_r]   <= f0_pc_i;
                done_r[tail_r] <= 1'b0;
`ifdef FETCH1_ERR_EN
                err_r[tail_r]  <= 1'b0;
`endif
            end
        end
    end

    fetch1_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .resp  (imem_resp_valid_i),
        .occ   (occ_r),
        .pend  (pend_r),
        .drop  (drop_r)
    );
endmodule

// fetch1_chk: simulation checks on response legality and the credit bound.
module fetch1_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          resp,
    input logic [CW-1:0] occ,
    input logic [CW-1:0] pend,
    input logic [CW-1:0] drop
);
    a_resp_legal: assert property (@(posedge clk) disable iff (!rst_n)
        resp |-> ((drop != {CW{1'b0}}) || (pend != {CW{1'b0}})));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, occ} + {1'b0, drop}) <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_fetch1.sv
// tb_fetch1: directed scenarios then random traffic, checked each cycle against a
// queue model of live fetches and outstanding memory requests.
module tb_fetch1;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f0_valid_i;
    logic [63:0] f0_pc_i;
    logic        redir_i;
    logic        stall_f0_o;
    logic        imem_req_valid_o;
    logic [63:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
`ifdef FETCH1_ERR_EN
    logic        imem_resp_err_i;
    logic        f1_err_o;
`endif
    logic        f1_valid_o;
    logic [63:0] f1_pc_o;
    logic [31:0] f1_inst_o;
    logic        dec_ready_i;

    fetch1 #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .f0_valid_i        (f0_valid_i),
        .f0_pc_i           (f0_pc_i),
        .redir_i           (redir_i),
        .stall_f0_o        (stall_f0_o),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
`ifdef FETCH1_ERR_EN
        .imem_resp_err_i   (imem_resp_err_i),
        .f1_err_o          (f1_err_o),
`endif
        .f1_valid_o        (f1_valid_o),
        .f1_pc_o           (f1_pc_o),
        .f1_inst_o         (f1_inst_o),
        .dec_ready_i       (dec_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [63:0] pc; bit got; } live_t;
    typedef struct { int id; logic [63:0] pc; int acc_cyc; bit flushed; } out_t;

    live_t live_q[$];
    out_t  out_q[$];
    int    cyc = 0;
    int    next_id = 0;
    int    n_assert = 0;
    int    n_fail = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ pc[63:32] ^ 32'h6B8F_3D21;
    endfunction

`ifdef FETCH1_ERR_EN
    function automatic logic err_of(input logic [63:0] pc);
        return pc[4:2] == 3'd1;
    endfunction
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check after settling, advance the model at the rising edge.
    task automatic step(input bit v, input logic [63:0] pc, input bit rd, input bit rdy,
                        input bit resp_en, input bit drdy, output bit acc);
        int    owed;
        bit    cf, exp_req, exp_stall, exp_f1v, pop, resp;
        out_t  r;
        resp = resp_en && (out_q.size() > 0) && (out_q[0].acc_cyc < cyc);
        f0_valid_i        = v;
        f0_pc_i           = pc;
        redir_i           = rd;
        imem_req_ready_i  = rdy;
        dec_ready_i       = drdy;
        imem_resp_valid_i = resp;
        imem_resp_data_i  = resp ? inst_of(out_q[0].pc) : 32'hDEAD_BEEF;
`ifdef FETCH1_ERR_EN
        imem_resp_err_i   = resp ? err_of(out_q[0].pc) : 1'b1;
`endif
        owed = 0;
        foreach (out_q[i]) if (out_q[i].flushed) owed++;
        cf        = (live_q.size() + owed) == DEPTH;
        exp_req   = v && !cf;
        exp_stall = cf || !rdy;
        acc       = exp_req && rdy;
        exp_f1v   = (live_q.size() > 0) && live_q[0].got && !rd;
        pop       = exp_f1v && drdy;
        #1;
        chk("req_valid", imem_req_valid_o, exp_req);
        chk("stall_f0", stall_f0_o, exp_stall);
        chk("req_addr", imem_req_addr_o, pc);
        chk("f1_valid", f1_valid_o, exp_f1v);
        if (exp_f1v) begin
            chk("f1_pc", f1_pc_o, live_q[0].pc);
            chk("f1_inst", f1_inst_o, inst_of(live_q[0].pc));
`ifdef FETCH1_ERR_EN
            chk("f1_err", f1_err_o, err_of(live_q[0].pc));
`endif
        end
        @(posedge clk);
        if (resp) begin
            r = out_q.pop_front();
            if (!r.flushed) foreach (live_q[i]) if (live_q[i].id == r.id) live_q[i].got = 1'b1;
        end
        if (rd) begin
            live_q.delete();
            foreach (out_q[i]) out_q[i].flushed = 1'b1;
        end else if (pop) begin
            void'(live_q.pop_front());
        end
        if (acc) begin
            live_q.push_back('{id: next_id, pc: pc, got: 1'b0});
            out_q.push_back('{id: next_id, pc: pc, acc_cyc: cyc, flushed: 1'b0});
            next_id++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bit a;
        repeat (6) step(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, a);
    endtask

    initial begin
        bit          a;
        bit          v, rd, rdy, ren, drdy;
        logic [63:0] f0pc, cur;

        rst_n = 1'b0;
        f0_valid_i = 1'b1; f0_pc_i = 64'h1234; redir_i = 1'b0;
        imem_req_ready_i = 1'b1; imem_resp_valid_i = 1'b0; imem_resp_data_i = 32'h0;
        dec_ready_i = 1'b1;
`ifdef FETCH1_ERR_EN
        imem_resp_err_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid_o, 1'b0);
        chk("rst_stall", stall_f0_o, 1'b0);
        chk("rst_addr", imem_req_addr_o, 64'h1234);
        chk("rst_f1_valid", f1_valid_o, 1'b0);
        chk("rst_f1_pc", f1_pc_o, 64'h0);
        chk("rst_f1_inst", f1_inst_o, 32'h0);
`ifdef FETCH1_ERR_EN
        chk("rst_f1_err", f1_err_o, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with one-cycle memory latency.
        step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b1, 1'b1, a);
        step(1'b1, 64'h1004, 1'b0, 1'b1, 1'b1, 1'b1, a);
        step(1'b1, 64'h1008, 1'b0, 1'b1, 1'b1, 1'b1, a);
        drain();

        // Backpressure from decode fills the queue, then one pop frees credit a cycle later.
        step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 64'h1004, 1'b0, 1'b1, 1'b1, 1'b0, a);
        repeat (3) step(1'b1, 64'h1008, 1'b0, 1'b1, 1'b1, 1'b0, a);
        step(1'b1, 64'h1008, 1'b0, 1'b1, 1'b1, 1'b1, a);
        step(1'b1, 64'h1008, 1'b0, 1'b1, 1'b1, 1'b0, a);
        drain();

        // Redirect with two requests in flight and no responses yet.
        step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b0, 1'b1, a);
        step(1'b1, 64'h1004, 1'b0, 1'b1, 1'b0, 1'b1, a);
        step(1'b1, 64'h2000, 1'b1, 1'b1, 1'b0, 1'b1, a);
        step(1'b1, 64'h2000, 1'b0, 1'b1, 1'b0, 1'b1, a);
        repeat (3) step(1'b1, 64'h2000, 1'b0, 1'b1, 1'b1, 1'b1, a);
        drain();

        // Redirect while the head is valid and a response lands in the same cycle.
        step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 64'h1004, 1'b0, 1'b1, 1'b1, 1'b0, a);
        step(1'b1, 64'h5000, 1'b1, 1'b1, 1'b1, 1'b1, a);
        step(1'b1, 64'h5000, 1'b0, 1'b1, 1'b1, 1'b1, a);
        drain();

        // Memory not ready for three cycles.
        repeat (3) step(1'b1, 64'h1000, 1'b0, 1'b0, 1'b1, 1'b1, a);
        step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b1, 1'b1, a);
        drain();

        // Reset mid-stream with two live entries.
        step(1'b1, 64'h3000, 1'b0, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 64'h3004, 1'b0, 1'b1, 1'b1, 1'b0, a);
        rst_n = 1'b0;
        f0_valid_i = 1'b1; f0_pc_i = 64'h3008; imem_resp_valid_i = 1'b0;
        #1;
        chk("midrst_f1_valid", f1_valid_o, 1'b0);
        chk("midrst_req_valid", imem_req_valid_o, 1'b0);
        chk("midrst_stall", stall_f0_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        live_q.delete();
        out_q.delete();
        step(1'b1, 64'h1000, 1'b0, 1'b1, 1'b1, 1'b1, a);
        step(1'b1, 64'h1004, 1'b0, 1'b1, 1'b1, 1'b1, a);
        drain();

        // Random traffic with an F0 model that holds its PC until accepted.
        f0pc = 64'h8000;
        for (int n = 0; n < 600; n++) begin
            v    = $urandom_range(0, 7) != 0;
            rd   = $urandom_range(0, 11) == 0;
            rdy  = $urandom_range(0, 3) != 0;
            ren  = $urandom_range(0, 2) != 0;
            drdy = $urandom_range(0, 3) != 0;
            cur  = rd ? ({$urandom, $urandom} & ~64'h3) : f0pc;
            step(v, cur, rd, rdy, ren, drdy, a);
            f0pc = a ? cur + 64'h4 : cur;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
